// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM states and nibble width.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Nibble datapath: 4-bit ripple-carry adder built from explicit full-adder equations.
module ripple_adder_4bit_structural
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic [NIBBLE-1:0] a_i,
    input  logic [NIBBLE-1:0] b_i,
    input  logic              c_i,
    output logic [NIBBLE-1:0] s_o,
    output logic              c_o
);

    logic [NIBBLE:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i + 1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = c[NIBBLE];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequencer that time-shares one 4-bit adder across a WIDTH-bit add/subtract,
// one nibble per clock, LSB first, between valid/ready operand and result ports.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIBS  = WIDTH / NIBBLE,
    localparam int NIB_W = $clog2(WIDTH / NIBBLE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output state_t           dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and stays high
    // with stable sum/carry_out/overflow until out_ready is seen.

    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBS - 1);

    state_t            state_q, state_d;
    logic [NIB_W-1:0]  nib_idx_q, nib_idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_eff_q, b_eff_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;

    logic [NIBBLE-1:0] a_nib;
    logic [NIBBLE-1:0] b_nib;
    logic [NIBBLE-1:0] add_sum;
    logic              add_carry;
    logic              last_nib;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (nib_idx_q == NIB_W'(i)) begin
                a_nib = a_q[i*NIBBLE +: NIBBLE];
                b_nib = b_eff_q[i*NIBBLE +: NIBBLE];
            end
        end
    end

    ripple_adder_4bit_structural u_adder (
        .a_i (a_nib),
        .b_i (b_nib),
        .c_i (carry_q),
        .s_o (add_sum),
        .c_o (add_carry)
    );

    assign last_nib = (nib_idx_q == LAST_NIB);

    always_comb begin
        state_d     = state_q;
        nib_idx_d   = nib_idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_eff_d     = b_eff_q;
        sum_d       = sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so the inversion and the +1 are folded in here.
                    a_d       = a;
                    b_eff_d   = sub ? ~b : b;
                    carry_d   = sub ? 1'b1 : carry_in;
                    sum_d     = '0;
                    nib_idx_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBS; i++) begin
                    if (nib_idx_q == NIB_W'(i)) begin
                        sum_d[i*NIBBLE +: NIBBLE] = add_sum;
                    end
                end
                carry_d = add_carry;
                if (last_nib) begin
                    carry_out_d = add_carry;
                    overflow_d  = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) &&
                                  (add_sum[NIBBLE-1] != a_q[WIDTH-1]);
                    state_d     = DONE;
                end else begin
                    nib_idx_d = nib_idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    nib_idx_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nib_idx_q   <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_eff_q     <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_idx_q   <= nib_idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_eff_q     <= b_eff_d;
            sum_q       <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign sum         = sum_q;
    assign carry_out   = carry_out_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(carry_out) && $stable(overflow)));

    a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready && busy));

    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        nib_idx_q <= LAST_NIB);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed and random operations on WIDTH=16 and
// WIDTH=32 instances, results checked by a queue-based scoreboard against an arithmetic model.
module tb_nibble_serial_adder_ctrl;
    import nibble_serial_adder_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- WIDTH=16 instance ----------------
    logic        in_valid16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0, out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, co16, ov16, busy16;
    logic [15:0] sum16;
    state_t      st16;

    nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .carry_in(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
        .carry_out(co16), .overflow(ov16), .busy(busy16), .dbg_state_o(st16)
    );

    // ---------------- WIDTH=32 instance ----------------
    logic        in_valid32 = 1'b0, cin32 = 1'b0, sub32 = 1'b0, out_ready32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0;
    logic        in_ready32, out_valid32, co32, ov32, busy32;
    logic [31:0] sum32;
    state_t      st32;

    nibble_serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .carry_in(cin32), .sub(sub32),
        .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
        .carry_out(co32), .overflow(ov32), .busy(busy32), .dbg_state_o(st32)
    );

    // ---------------- scoreboard queues: {overflow, carry_out, sum} ----------------
    logic [17:0] exp16_q[$];
    logic [33:0] exp32_q[$];
    int          lat16_q[$];
    int          lat32_q[$];

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic s,
                         output logic [31:0] r, output logic c, output logic v);
        longint lim, ua, ub, sa, sb, full, sres, ci;
        lim  = longint'(1) << (w - 1);
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= lim) ? ua - 2 * lim : ua;
        sb   = (ub >= lim) ? ub - 2 * lim : ub;
        ci   = cin ? 1 : 0;
        if (s) begin
            full = ua - ub;
            c    = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + ci;
            c    = (full >= 2 * lim);
            sres = sa + sb + ci;
        end
        v = (sres >= lim) || (sres < -lim);
        r = 32'(full);
        if (w < 32) r = r & ((32'd1 << w) - 32'd1);
    endtask

    task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic run_monitor();
        logic        prev16 = 1'b0, prev32 = 1'b0;
        logic [17:0] e16;
        logic [33:0] e32;
        int          l;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev16 = 1'b0;
                prev32 = 1'b0;
            end else begin
                if (out_valid16 && !prev16) begin
                    if (lat16_q.size() == 0) chk("lat16_unexpected", 34'(cyc), 34'h3_FFFF_FFFF);
                    else begin
                        l = lat16_q.pop_front();
                        chk("lat16", 34'(cyc - l), 34'd4);
                    end
                end
                if (out_valid16 && out_ready16) begin
                    if (exp16_q.size() == 0) chk("res16_unexpected", {ov16, co16, sum16}, 34'h3_FFFF_FFFF);
                    else begin
                        e16 = exp16_q.pop_front();
                        chk("res16", {ov16, co16, sum16}, 34'(e16));
                    end
                end
                if (out_valid32 && !prev32) begin
                    if (lat32_q.size() == 0) chk("lat32_unexpected", 34'(cyc), 34'h3_FFFF_FFFF);
                    else begin
                        l = lat32_q.pop_front();
                        chk("lat32", 34'(cyc - l), 34'd8);
                    end
                end
                if (out_valid32 && out_ready32) begin
                    if (exp32_q.size() == 0) chk("res32_unexpected", {ov32, co32, sum32}, 34'h3_FFFF_FFFF);
                    else begin
                        e32 = exp32_q.pop_front();
                        chk("res32", {ov32, co32, sum32}, e32);
                    end
                end
                prev16 = out_valid16;
                prev32 = out_valid32;
            end
        end
    endtask

    // ---------------- drivers (called just after a rising edge) ----------------
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic s, input bit track, input logic [17:0] exp);
        int g = 0;
        a16 = a; b16 = b; cin16 = cin; sub16 = s; in_valid16 = 1'b1;
        @(negedge clk);
        while (!in_ready16 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready16) chk("accept16_timeout", 34'(in_ready16), 34'd1);
        else if (track) begin
            exp16_q.push_back(exp);
            lat16_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1 in_valid16 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic s, input logic [33:0] exp);
        int g = 0;
        a32 = a; b32 = b; cin32 = cin; sub32 = s; in_valid32 = 1'b1;
        @(negedge clk);
        while (!in_ready32 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready32) chk("accept32_timeout", 34'(in_ready32), 34'd1);
        else begin
            exp32_q.push_back(exp);
            lat32_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1 in_valid32 = 1'b0;
    endtask

    task automatic wait_idle(input bit w32);
        int g = 0;
        @(negedge clk);
        while (g < 100 && (w32 ? (exp32_q.size() != 0 || busy32) : (exp16_q.size() != 0 || busy16))) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk(w32 ? "drain32_timeout" : "drain16_timeout", 34'(g), 34'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r, ra, rb;
        logic        c, v, rc, rs;
        int          nv;

        fork
            run_monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  34'(in_ready16),  34'd1);
        chk("rst_out_valid", 34'(out_valid16), 34'd0);
        chk("rst_busy",      34'(busy16),      34'd0);
        chk("rst_result",    {ov16, co16, sum16}, 34'd0);
        chk("rst_state",     34'(st16),        34'(IDLE));
        @(posedge clk);
        #1;

        // Directed add/sub cases with hand-computed results.
        send16(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h0100});
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0000});
        send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h8000});
        send16(16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 16'h1000});
        send16(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        send16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send16(16'h0003, 16'h0003, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000});
        wait_idle(1'b0);

        // Back-pressure in DONE: result and flags hold, new operands are refused.
        out_ready16 = 1'b0;
        send16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h5555});
        nv = 0;
        @(negedge clk);
        while (!out_valid16 && nv < 20) begin
            @(negedge clk);
            nv++;
        end
        chk("bp_reach_done", 34'(out_valid16), 34'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 in_valid16 = 1'b1;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            @(negedge clk);
            chk("bp_hold_result", {ov16, co16, sum16}, {2'b00, 16'h5555});
            chk("bp_in_ready",    34'(in_ready16),  34'd0);
            chk("bp_out_valid",   34'(out_valid16), 34'd1);
        end
        @(posedge clk);
        #1 out_ready16 = 1'b1;
        in_valid16 = 1'b0;
        wait_idle(1'b0);
        chk("idle_hold_result", {ov16, co16, sum16}, {2'b00, 16'h5555});

        // Reset while nibble 2 is being computed: transaction is dropped.
        send16(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy",   34'(busy16),      34'd0);
        chk("midrst_result", {ov16, co16, sum16}, 34'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid16) nv++;
        end
        chk("midrst_no_out_valid", 34'(nv), 34'd0);
        chk("midrst_in_ready", 34'(in_ready16), 34'd1);
        @(posedge clk);
        #1;
        send16(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'hBCDE});
        send16(16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 16'h8001});
        wait_idle(1'b0);

        // Random WIDTH=16 operations.
        for (int i = 0; i < 40; i++) begin
            ra = {16'h0, 16'($urandom)};
            rb = {16'h0, 16'($urandom)};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(16, ra, rb, rc, rs, r, c, v);
            send16(ra[15:0], rb[15:0], rc, rs, 1'b1, {v, c, r[15:0]});
        end
        wait_idle(1'b0);

        // Random back-to-back WIDTH=32 operations with the sink always ready.
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 16 == 0) ra = 32'h7FFF_FFFF;
            if (i % 16 == 8) rb = 32'h8000_0000;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(32, ra, rb, rc, rs, r, c, v);
            send32(ra, rb, rc, rs, {v, c, r});
        end
        wait_idle(1'b1);

        chk("end_q16_empty", 34'(exp16_q.size()), 34'd0);
        chk("end_q32_empty", 34'(exp32_q.size()), 34'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
